// File: rtl/fetch_pkg.sv
//------------------------------------------------------------------------------
// Module   : fetch_pkg
// Brief    : Shared constants for the instruction fetch stage.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  localparam int          INSTR_WIDTH      = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam int          PC_INCR          = 4;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
//------------------------------------------------------------------------------
// Module   : fetch_fifo
// Brief    : Fetch buffer holding {pc, instr} pairs with sync push/pop/flush.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_pc,
  input  logic [WIDTH-1:0]           push_instr,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head_pc,
  output logic [WIDTH-1:0]           head_instr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] pc_mem_q    [DEPTH];
  logic [WIDTH-1:0] pc_mem_d    [DEPTH];
  logic [WIDTH-1:0] instr_mem_q [DEPTH];
  logic [WIDTH-1:0] instr_mem_d [DEPTH];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        pc_mem_d[tail_q]    = push_pc;
        instr_mem_d[tail_q] = push_instr;
        tail_d              = tail_q + AW'(1);
      end
      if (pop) begin
        head_d = head_q + AW'(1);
      end
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  assign count      = count_q;
  assign head_pc    = (count_q != '0) ? pc_mem_q[head_q]    : '0;
  assign head_instr = (count_q != '0) ? instr_mem_q[head_q] : '0;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
//------------------------------------------------------------------------------
// Module   : instr_fetch
// Brief    : PC register, next-PC selection and fetch buffer control.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = INSTR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT),
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [DATA_WIDTH-1:0] out_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  push;
  logic                  pop;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign push      = fetch_en && !redirect_valid && (!full || pop);
  assign imem_addr = pc_q;

  // Redirect targets are forced word aligned; increment wraps modulo 2^DATA_WIDTH.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & ~DATA_WIDTH'(3);
    end else if (push) begin
      pc_d = pc_q + DATA_WIDTH'(PC_INCR);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .pop        (pop),
    .push_pc    (pc_q),
    .push_instr (imem_rd),
    .count      (count),
    .head_pc    (out_pc),
    .head_instr (out_instr)
  );

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set instruction and address width.
REQ-002 Parameter RESET_PC, default 32'h0040_0000, SHALL set the PC value loaded on reset.
REQ-003 Parameter FIFO_DEPTH, default 2, SHALL set the fetch buffer depth (power of two, >=2).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 fetch_en  input  1  SHALL enable fetching when high.
REQ-007 redirect_valid  input  1  SHALL request a PC redirect (branch/jump) this cycle.
REQ-008 redirect_pc  input  DATA_WIDTH  SHALL carry the redirect target.
REQ-009 imem_addr  output  DATA_WIDTH  SHALL drive the byte address to the instruction memory.
REQ-010 imem_rd  input  DATA_WIDTH  SHALL be the combinational read data for imem_addr.
REQ-011 out_valid  output  1  SHALL indicate a buffered instruction is presented to decode.
REQ-012 out_ready  input  1  SHALL indicate decode accepts the presented instruction.
REQ-013 out_instr  output  DATA_WIDTH  SHALL be the instruction word at the buffer head.
REQ-014 out_pc  output  DATA_WIDTH  SHALL be the byte address of out_instr.

Function
REQ-015 imem_addr SHALL equal the PC register combinationally (zero added latency).
REQ-016 pop SHALL occur when out_valid && out_ready && !redirect_valid.
REQ-017 push SHALL occur when fetch_en && !redirect_valid && (count < FIFO_DEPTH || pop); push writes {PC, imem_rd} at tail and PC <= PC + 4.
REQ-018 Push while full SHALL be allowed only with a same-cycle pop; count then stays FIFO_DEPTH.
REQ-019 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-020 With fetch_en low, PC and buffer contents SHALL hold; pops continue.
REQ-021 redirect_valid SHALL take priority: count, head and tail cleared to 0, PC <= {redirect_pc[31:2], 2'b00}, no push, no pop that cycle.
REQ-022 Fetch from redirected target SHALL begin the cycle after redirect (one-cycle bubble).
REQ-023 PC increment SHALL wrap modulo 2^DATA_WIDTH (32'hFFFF_FFFC + 4 -> 32'h0000_0000).
REQ-024 out_valid SHALL be (count != 0); out_instr/out_pc SHALL be the head entry, 0 when empty.
REQ-025 Head entry and out_* values SHALL remain stable while out_valid && !out_ready && !redirect_valid.
REQ-026 Instruction order presented to decode SHALL match fetch order; no entry duplicated or dropped except by redirect flush.

Reset
REQ-027 On rst high at a rising edge: PC <= RESET_PC, count/head/tail <= 0, all buffer entries <= 0.
REQ-028 After reset: out_valid=0, out_instr=0, out_pc=0, imem_addr=RESET_PC.
REQ-029 rst SHALL override redirect_valid, push and pop in the same cycle; in-flight entries are discarded.

Structure
REQ-030 RESET_PC, instruction width and PC increment constant (4) SHALL live in shared package fetch_pkg.
REQ-031 Buffer storage, pointers and count SHALL be one sub-module, fetch_fifo (sync push/pop/flush, FIFO_DEPTH entries).
REQ-032 PC register, next-PC mux and push/pop control SHALL reside in instr_fetch.

Verification
REQ-033 Reset, fetch_en=1, out_ready=1, imem returns addr-derived word -> out_pc 0x0040_0000, 0x0040_0004, 0x0040_0008 on consecutive cycles, out_valid from cycle 1.
REQ-034 out_ready=0 for 5 cycles -> count saturates at 2, PC stops at 0x0040_0008, out_pc holds 0x0040_0000; release -> order 0x...000, 004, 008 preserved.
REQ-035 Buffer full plus redirect_valid=1, redirect_pc=0x0040_0103 -> next cycle out_valid=0, imem_addr=0x0040_0100; following cycle out_pc=0x0040_0100.
REQ-036 PC forced to 0xFFFF_FFFC via redirect -> next pushed out_pc values 0xFFFF_FFFC then 0x0000_0000.
REQ-037 rst asserted for one cycle while full and redirect_valid=1 -> out_valid=0, imem_addr=0x0040_0000, redirect ignored.
REQ-038 Full buffer, out_ready=1, fetch_en=1 for 10 cycles -> count stays 2, one instruction retired per cycle, no gaps.
